led_pattern_gen: RTL and testbench

Parametrised LED pattern generator. It is the successor to the fixed 4-bit ripple-count blinker. A programmable prescaler divides clk down to a step tick, and on each tick an N-channel pattern register advances according to a selectable mode. It drives the board LEDs directly, and a top-level or control block supplies mode, divider and enable.

---
 rtl/led_pattern_gen.sv | 101 ++++++++++
 tb/tb_led_pattern_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// Programmable LED pattern generator: a prescaler divides clk into a step tick,
// and each tick advances an N-channel pattern in count, chase, bounce or blink mode.
module led_pattern_gen #(
    parameter int unsigned NUM_LEDS   = 4,
    parameter int unsigned DIV_W      = 24,
    parameter int unsigned RST_DIV_EN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [DIV_W-1:0]    div,
    output logic [NUM_LEDS-1:0] led,
    output logic                tick,
    output logic                dir
);
    typedef enum logic [1:0] {
        M_COUNT  = 2'd0,
        M_CHASE  = 2'd1,
        M_BOUNCE = 2'd2,
        M_BLINK  = 2'd3
    } mode_e;

    localparam logic [NUM_LEDS-1:0] LED_ONE = NUM_LEDS'(1);
    localparam logic [DIV_W-1:0]    CNT_ONE = DIV_W'(1);

    mode_e               mode_sel;
    mode_e               mode_prev;
    logic [DIV_W-1:0]    cnt;
    logic [DIV_W-1:0]    cnt_n;
    logic [NUM_LEDS-1:0] led_n;
    logic                bdir;
    logic                bdir_n;
    logic                tick_n;
    logic                pre_en;
    logic                step;

    function automatic logic [NUM_LEDS-1:0] init_pattern(input mode_e m);
        return (m == M_CHASE || m == M_BOUNCE) ? LED_ONE : '0;
    endfunction

    assign mode_sel = mode_e'(mode);
    assign pre_en   = (RST_DIV_EN != 0) ? en : 1'b1;
    assign step     = pre_en && (cnt >= div);

    always_comb begin
        led_n  = led;
        bdir_n = bdir;
        cnt_n  = cnt;
        tick_n = 1'b0;
        if (mode_sel != mode_prev) begin
            // A mode switch reloads the pattern and restarts the period, outranking any due step
            led_n  = init_pattern(mode_sel);
            bdir_n = 1'b1;
            cnt_n  = '0;
        end else begin
            if (pre_en) begin
                cnt_n = step ? '0 : cnt + CNT_ONE;
            end
            if (step && en) begin
                tick_n = 1'b1;
                case (mode_prev)
                    M_COUNT: led_n = led + LED_ONE;
                    M_CHASE: led_n = (led << 1) | (led >> (NUM_LEDS - 1));
                    M_BOUNCE: begin
                        if (NUM_LEDS > 1) begin
                            if (bdir) begin
                                led_n = led << 1;
                                if (led_n[NUM_LEDS-1]) bdir_n = 1'b0;
                            end else begin
                                led_n = led >> 1;
                                if (led_n[0]) bdir_n = 1'b1;
                            end
                        end
                    end
                    M_BLINK: led_n = ~led;
                    default: led_n = led;
                endcase
            end
        end
    end

    // dir is the bounce direction qualified by mode, kept as its own register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            tick      <= 1'b0;
            bdir      <= 1'b1;
            led       <= init_pattern(mode_sel);
            mode_prev <= mode_sel;
            dir       <= (mode_sel == M_BOUNCE);
        end else begin
            cnt       <= cnt_n;
            tick      <= tick_n;
            bdir      <= bdir_n;
            led       <= led_n;
            mode_prev <= mode_sel;
            dir       <= bdir_n && (mode_sel == M_BOUNCE);
        end
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: directed vectors, hand-written corner
// sequences and randomized stimulus against a position/value reference model.
module tb_led_pattern_gen;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    mode;
    logic [DW-1:0] div;
    logic [3:0]    led_a;
    logic          tick_a, dir_a;
    logic [0:0]    led_b;
    logic          tick_b, dir_b;
    logic [3:0]    led_c;
    logic          tick_c, dir_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    led_pattern_gen #(.NUM_LEDS(4), .DIV_W(DW), .RST_DIV_EN(1)) u_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .div(div),
        .led(led_a), .tick(tick_a), .dir(dir_a));
    led_pattern_gen #(.NUM_LEDS(1), .DIV_W(DW), .RST_DIV_EN(1)) u_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .div(div),
        .led(led_b), .tick(tick_b), .dir(dir_b));
    led_pattern_gen #(.NUM_LEDS(4), .DIV_W(DW), .RST_DIV_EN(0)) u_c (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .div(div),
        .led(led_c), .tick(tick_c), .dir(dir_c));

    // Reference model: lit position for chase/bounce, integer value for count/blink
    int mn[3]   = '{4, 1, 4};
    int mrde[3] = '{1, 1, 0};
    int m_cnt[3], m_val[3], m_pos[3], m_mode[3];
    bit m_up[3], m_tick[3];

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            bit run;
            bit stp;
            if (rst || int'(mode) != m_mode[k]) begin
                m_mode[k] = int'(mode);
                m_cnt[k]  = 0;
                m_tick[k] = 0;
                m_up[k]   = 1;
                m_pos[k]  = 0;
                m_val[k]  = 0;
            end else begin
                run = (mrde[k] != 0) ? en : 1'b1;
                stp = run && (m_cnt[k] >= int'(div));
                m_tick[k] = stp && en;
                if (run) m_cnt[k] = stp ? 0 : (m_cnt[k] + 1) % 256;
                if (m_tick[k]) begin
                    case (m_mode[k])
                        0: m_val[k] = (m_val[k] + 1) % (1 << mn[k]);
                        1: m_pos[k] = (m_pos[k] + 1) % mn[k];
                        2: if (mn[k] > 1) begin
                               m_pos[k] = m_up[k] ? m_pos[k] + 1 : m_pos[k] - 1;
                               if (m_pos[k] == mn[k] - 1) m_up[k] = 0;
                               else if (m_pos[k] == 0) m_up[k] = 1;
                           end
                        default: m_val[k] = (m_val[k] != 0) ? 0 : 1;
                    endcase
                end
            end
        end
    endtask

    function automatic int exp_led(int k);
        case (m_mode[k])
            0:       return m_val[k];
            1, 2:    return 1 << m_pos[k];
            default: return (m_val[k] != 0) ? (1 << mn[k]) - 1 : 0;
        endcase
    endfunction

    function automatic int exp_dir(int k);
        return (m_mode[k] == 2) ? int'(m_up[k]) : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("a.led",  32'(led_a),  exp_led(0));
        chk("a.tick", 32'(tick_a), 32'(m_tick[0]));
        chk("a.dir",  32'(dir_a),  exp_dir(0));
        chk("b.led",  32'(led_b),  exp_led(1));
        chk("b.tick", 32'(tick_b), 32'(m_tick[1]));
        chk("b.dir",  32'(dir_b),  exp_dir(1));
        chk("c.led",  32'(led_c),  exp_led(2));
        chk("c.tick", 32'(tick_c), 32'(m_tick[2]));
        chk("c.dir",  32'(dir_c),  exp_dir(2));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    typedef struct {
        logic          r;
        logic          e;
        logic [1:0]    m;
        logic [DW-1:0] d;
        logic [3:0]    led;
        logic          tk;
        logic          dr;
    } vec_t;

    vec_t vt[14];

    initial begin
        // Bounce at div=0, then blink, an en=0 hold and switch to count
        vt[0]  = '{1'b1, 1'b1, 2'd2, 8'd0, 4'h1, 1'b0, 1'b1};
        vt[1]  = '{1'b0, 1'b1, 2'd2, 8'd0, 4'h2, 1'b1, 1'b1};
        vt[2]  = '{1'b0, 1'b1, 2'd2, 8'd0, 4'h4, 1'b1, 1'b1};
        vt[3]  = '{1'b0, 1'b1, 2'd2, 8'd0, 4'h8, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 2'd2, 8'd0, 4'h4, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 2'd2, 8'd0, 4'h2, 1'b1, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 2'd2, 8'd0, 4'h1, 1'b1, 1'b1};
        vt[7]  = '{1'b0, 1'b1, 2'd2, 8'd0, 4'h2, 1'b1, 1'b1};
        vt[8]  = '{1'b0, 1'b1, 2'd3, 8'd0, 4'h0, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 2'd3, 8'd0, 4'hF, 1'b1, 1'b0};
        vt[10] = '{1'b0, 1'b1, 2'd3, 8'd0, 4'h0, 1'b1, 1'b0};
        vt[11] = '{1'b0, 1'b0, 2'd3, 8'd0, 4'h0, 1'b0, 1'b0};
        vt[12] = '{1'b0, 1'b1, 2'd0, 8'd0, 4'h0, 1'b0, 1'b0};
        vt[13] = '{1'b0, 1'b1, 2'd0, 8'd0, 4'h1, 1'b1, 1'b0};

        rst = 1'b1; en = 1'b1; mode = 2'd0; div = 8'd3;

        // Count mode, div=3: reset state, then a tick every 4th cycle through a full wrap
        cycle();
        chk("rst.led", 32'(led_a), 32'h0);
        chk("rst.tick", 32'(tick_a), 32'h0);
        chk("rst.dir", 32'(dir_a), 32'h0);
        rst = 1'b0;
        for (int t = 1; t <= 17; t++) begin
            for (int c = 1; c <= 4; c++) begin
                cycle();
                if (c < 4) begin
                    chk("t1.tick0", 32'(tick_a), 32'h0);
                    chk("t1.hold", 32'(led_a), 32'((t - 1) % 16));
                end else begin
                    chk("t1.tick1", 32'(tick_a), 32'h1);
                    chk("t1.led", 32'(led_a), 32'(t % 16));
                end
            end
        end

        for (int i = 0; i < 14; i++) begin
            rst = vt[i].r; en = vt[i].e; mode = vt[i].m; div = vt[i].d;
            cycle();
            chk("vec.led", 32'(led_a), 32'(vt[i].led));
            chk("vec.tick", 32'(tick_a), 32'(vt[i].tk));
            chk("vec.dir", 32'(dir_a), 32'(vt[i].dr));
        end

        // Mode switch coinciding with a due step
        rst = 1'b1; en = 1'b1; mode = 2'd0; div = 8'd3;
        cycle();
        rst = 1'b0;
        repeat (23) cycle();
        chk("t3.led5", 32'(led_a), 32'h5);
        mode = 2'd1;
        cycle();
        chk("t3.reload", 32'(led_a), 32'h1);
        chk("t3.notick", 32'(tick_a), 32'h0);
        for (int c = 1; c <= 4; c++) begin
            cycle();
            chk("t3.tick", 32'(tick_a), (c == 4) ? 32'h1 : 32'h0);
            chk("t3.led", 32'(led_a), (c == 4) ? 32'h2 : 32'h1);
        end

        // div lowered below the running count
        rst = 1'b1; mode = 2'd1; div = 8'd9;
        cycle();
        rst = 1'b0;
        repeat (7) cycle();
        chk("t4.pre", 32'(tick_a), 32'h0);
        div = 8'd2;
        cycle();
        chk("t4.tick", 32'(tick_a), 32'h1);
        chk("t4.led", 32'(led_a), 32'h2);
        for (int r = 0; r < 2; r++) begin
            for (int c = 1; c <= 3; c++) begin
                cycle();
                chk("t4.ptick", 32'(tick_a), (c == 3) ? 32'h1 : 32'h0);
                if (c == 3) chk("t4.pled", 32'(led_a), (r == 0) ? 32'h4 : 32'h8);
            end
        end

        // Blink with enable dropped mid-period
        rst = 1'b1; mode = 2'd3; div = 8'd1;
        cycle();
        rst = 1'b0;
        repeat (3) cycle();
        chk("t5.on", 32'(led_a), 32'hF);
        en = 1'b0;
        repeat (5) begin
            cycle();
            chk("t5.frz", 32'(led_a), 32'hF);
            chk("t5.tick", 32'(tick_a), 32'h0);
        end
        en = 1'b1;
        cycle();
        chk("t5.resume", 32'(tick_a), 32'h1);
        chk("t5.off", 32'(led_a), 32'h0);

        // Single-cycle reset mid-chase, both widths
        rst = 1'b1; mode = 2'd1; div = 8'd2;
        cycle();
        rst = 1'b0;
        repeat (7) cycle();
        chk("t6.led4", 32'(led_a), 32'h4);
        rst = 1'b1;
        cycle();
        chk("t6.rled", 32'(led_a), 32'h1);
        chk("t6.rtick", 32'(tick_a), 32'h0);
        chk("t6.bled", 32'(led_b), 32'h1);
        rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            cycle();
            chk("t6.tick", 32'(tick_a), (c == 3) ? 32'h1 : 32'h0);
            chk("t6.btick", 32'(tick_b), (c == 3) ? 32'h1 : 32'h0);
            chk("t6.bhold", 32'(led_b), 32'h1);
            if (c == 3) chk("t6.led2", 32'(led_a), 32'h2);
        end

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            en  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) div = 8'($urandom_range(0, 5));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
